pp_accumulator: RTL

PP_ACCUMULATOR -- requirements
Module: pp_accumulator

---
 rtl/pp_acc_pkg.sv | 28 ++
 rtl/pp_accumulator_csa.sv | 16 +
 rtl/pp_accumulator.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pp_acc_pkg.sv
// Shared constants for the partial-product accumulator: widths, FSM encoding,
// ACCUM step counts for both builds (PP_ACC_CSA_EN selects carry-save), and the carry helper.
package pp_acc_pkg;

  localparam int NUM_PP = 8;
  localparam int PP_W   = 32;
  localparam int STEP_W = 4;

  typedef logic [PP_W-1:0] pp_word_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCUM   = 2'd1;
  localparam logic [1:0] ST_RESOLVE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

`ifdef PP_ACC_CSA_EN
  localparam logic [STEP_W-1:0] ACC_STEPS = 4'd4;
`else
  localparam logic [STEP_W-1:0] ACC_STEPS = 4'd8;
`endif
  localparam logic [STEP_W-1:0] LAST_STEP = ACC_STEPS - 4'd1;

  // Per-bit majority: the unshifted carry vector of a full-adder row.
  function automatic pp_word_t maj3(input pp_word_t a, input pp_word_t b, input pp_word_t c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/pp_accumulator_csa.sv
// One PP_W-wide row of independent full adders (3:2 compressor).
// The carry output is unshifted; the parent aligns it one bit left.
module csa_3to2
  import pp_acc_pkg::*;
(
  input  logic [PP_W-1:0] a_i,
  input  logic [PP_W-1:0] b_i,
  input  logic [PP_W-1:0] c_i,
  output logic [PP_W-1:0] sum_o,
  output logic [PP_W-1:0] carry_o
);

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign carry_o = maj3(a_i, b_i, c_i);

endmodule

// File: rtl/pp_accumulator.sv
// Sums eight pre-shifted Booth partial products mod 2^32 through IDLE/ACCUM/RESOLVE/DONE.
// Build option PP_ACC_CSA_EN: two chained 3:2 rows per step instead of one ripple add.
module pp_accumulator
  import pp_acc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PP_W-1:0] pp0,
  input  logic [PP_W-1:0] pp1,
  input  logic [PP_W-1:0] pp2,
  input  logic [PP_W-1:0] pp3,
  input  logic [PP_W-1:0] pp4,
  input  logic [PP_W-1:0] pp5,
  input  logic [PP_W-1:0] pp6,
  input  logic [PP_W-1:0] pp7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PP_W-1:0] out_product,
  output logic            busy
);

  logic [1:0]        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [PP_W-1:0]   sum_q, sum_d;
  logic [PP_W-1:0]   carry_q, carry_d;
  logic [PP_W-1:0]   out_product_q, out_product_d;
  logic              out_valid_q, in_ready_q, busy_q;
  logic [PP_W-1:0]   pp_q [NUM_PP];
  logic              load_s;
  logic [PP_W-1:0]   step_sum_s;
  logic [PP_W-1:0]   step_carry_s;

`ifdef PP_ACC_CSA_EN
  logic [2:0]      idx_a_s, idx_b_s;
  logic [PP_W-1:0] row0_sum_s, row0_carry_s, row0_carry_sh_s;
  logic [PP_W-1:0] row1_sum_s, row1_carry_s;

  assign idx_a_s = {step_q[1:0], 1'b0};
  assign idx_b_s = {step_q[1:0], 1'b1};
  assign row0_carry_sh_s = row0_carry_s << 1;

  csa_3to2 u_row0 (
    .a_i     (sum_q),
    .b_i     (carry_q),
    .c_i     (pp_q[idx_a_s]),
    .sum_o   (row0_sum_s),
    .carry_o (row0_carry_s)
  );

  csa_3to2 u_row1 (
    .a_i     (row0_sum_s),
    .b_i     (row0_carry_sh_s),
    .c_i     (pp_q[idx_b_s]),
    .sum_o   (row1_sum_s),
    .carry_o (row1_carry_s)
  );

  assign step_sum_s   = row1_sum_s;
  assign step_carry_s = row1_carry_s << 1;
`else
  assign step_sum_s   = sum_q + pp_q[step_q[2:0]];
  assign step_carry_s = '0;
`endif

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    sum_d         = sum_q;
    carry_d       = carry_q;
    out_product_d = out_product_q;
    load_s        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          load_s  = 1'b1;
          sum_d   = '0;
          carry_d = '0;
          step_d  = '0;
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        sum_d   = step_sum_s;
        carry_d = step_carry_s;
        step_d  = step_q + 4'd1;
        if (step_q == LAST_STEP) begin
          state_d = ST_RESOLVE;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_RESOLVE: begin
        out_product_d = sum_q + carry_q;
        state_d       = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      step_q        <= '0;
      sum_q         <= '0;
      carry_q       <= '0;
      out_product_q <= '0;
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      sum_q         <= sum_d;
      carry_q       <= carry_d;
      out_product_q <= out_product_d;
      out_valid_q   <= (state_d == ST_DONE);
      in_ready_q    <= (state_d == ST_IDLE);
      busy_q        <= (state_d != ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PP; i++) pp_q[i] <= '0;
    end else if (load_s) begin
      pp_q[0] <= pp0;
      pp_q[1] <= pp1;
      pp_q[2] <= pp2;
      pp_q[3] <= pp3;
      pp_q[4] <= pp4;
      pp_q[5] <= pp5;
      pp_q[6] <= pp6;
      pp_q[7] <= pp7;
    end else begin
      for (int i = 0; i < NUM_PP; i++) pp_q[i] <= pp_q[i];
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;
  assign busy        = busy_q;

endmodule
